lieat_exu_wbarb: RTL and testbench

- Parametrised writeback arbiter for the EXU. Merges NUM_CH functional-unit result channels (COM, LSU, MULDIV, and any future units) into one registered regfile writeback/commit port.
- Arbitration is round-robin among eligible channels. A per-channel OITF WAW-dependency mask makes a channel ineligible.
- Sits between the FU output handshakes and the regfile/commit logic. Replaces the fixed three-input writeback mux.

---
 rtl/lieat_exu_wbarb_pkg.sv | 11 +
 rtl/lieat_rr_arb.sv | 33 +++
 rtl/lieat_exu_wbarb.sv | 131 +++++++++++++
 tb/tb_lieat_exu_wbarb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lieat_exu_wbarb_pkg.sv
// lieat_exu_wbarb_pkg: shared EXU writeback widths and result-channel IDs.
package lieat_exu_wbarb_pkg;

    localparam int LIEAT_XLEN    = 64;
    localparam int LIEAT_REG_IDX = 5;

    localparam int CH_COM    = 0;
    localparam int CH_LSU    = 1;
    localparam int CH_MULDIV = 2;

endpackage

// File: rtl/lieat_rr_arb.sv
// lieat_rr_arb: one-hot request picker, round-robin starting at ptr.
// Define LIEAT_WBARB_FIXPRIO_EN for fixed priority (lowest index wins).
module lieat_rr_arb #(
    parameter int NUM_CH = 3,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt
);

`ifdef LIEAT_WBARB_FIXPRIO_EN
    logic unused_ptr;

    assign unused_ptr = ^ptr;
    assign gnt        = req & (~req + NUM_CH'(1));
`else
    logic [2*NUM_CH-1:0] dbl;
    logic [2*NUM_CH-1:0] back;
    logic [NUM_CH-1:0]   rot;
    logic [NUM_CH-1:0]   first;
    logic                unused_bits;

    // Rotate ptr down to bit 0, keep the lowest set bit, rotate back.
    assign dbl         = {req, req} >> ptr;
    assign rot         = dbl[NUM_CH-1:0];
    assign first       = rot & (~rot + NUM_CH'(1));
    assign back        = {first, first} << ptr;
    assign gnt         = back[2*NUM_CH-1:NUM_CH];
    assign unused_bits = ^{dbl[2*NUM_CH-1:NUM_CH], back[NUM_CH-1:0]};
`endif

endmodule

// File: rtl/lieat_exu_wbarb.sv
// lieat_exu_wbarb: merges FU result channels into one registered writeback port.
// LIEAT_WBARB_FIXPRIO_EN selects fixed priority instead of round-robin.
module lieat_exu_wbarb
    import lieat_exu_wbarb_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int XLEN    = LIEAT_XLEN,
    parameter int REG_IDX = LIEAT_REG_IDX,
    parameter int LSU_CH  = CH_LSU
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH*XLEN-1:0]    ch_pc,
    input  logic [NUM_CH-1:0]         ch_wen,
    input  logic [NUM_CH*REG_IDX-1:0] ch_rd,
    input  logic [NUM_CH*XLEN-1:0]    ch_data,
    input  logic [NUM_CH-1:0]         ch_ebreak,
    input  logic [NUM_CH-1:0]         ch_mmio,
    input  logic [NUM_CH-1:0]         waw_dep,
    output logic                      wbck_o_valid,
    input  logic                      wbck_o_ready,
    output logic [NUM_CH-1:0]         wbck_o_op,
    output logic [XLEN-1:0]           wbck_o_pc,
    output logic                      wbck_o_en,
    output logic [REG_IDX-1:0]        wbck_o_rd,
    output logic [XLEN-1:0]           wbck_o_data,
    output logic                      wbck_o_lsu,
    output logic                      wbck_o_mmio,
    output logic                      wbck_o_ebreak
);

    localparam int PTR_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]  elig;
    logic [NUM_CH-1:0]  gnt;
    logic               adv;
    logic               hs;
    logic               wen_q;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [XLEN-1:0]    sel_pc;
    logic [XLEN-1:0]    sel_data;
    logic [REG_IDX-1:0] sel_rd;
    logic               sel_wen;
    logic               sel_ebreak;
    logic               sel_mmio;

    assign elig      = ch_valid & ~waw_dep;
    assign adv       = ~wbck_o_valid | wbck_o_ready;
    assign ch_ready  = reset ? '0 : (gnt & {NUM_CH{adv}});
    assign hs        = |ch_ready;
    assign wbck_o_en = wbck_o_valid & wen_q;

    lieat_rr_arb #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        gidx       = '0;
        sel_pc     = '0;
        sel_data   = '0;
        sel_rd     = '0;
        sel_wen    = 1'b0;
        sel_ebreak = 1'b0;
        sel_mmio   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                gidx       = PTR_W'(i);
                sel_pc     = ch_pc[i*XLEN +: XLEN];
                sel_data   = ch_data[i*XLEN +: XLEN];
                sel_rd     = ch_rd[i*REG_IDX +: REG_IDX];
                sel_wen    = ch_wen[i];
                sel_ebreak = ch_ebreak[i];
                sel_mmio   = ch_mmio[i];
            end
        end
    end

    assign ptr_nxt = (gidx == PTR_W'(NUM_CH-1)) ? '0 : gidx + PTR_W'(1);

`ifdef LIEAT_WBARB_FIXPRIO_EN
    logic unused_ptr_nxt;

    assign ptr            = '0;
    assign unused_ptr_nxt = ^ptr_nxt;
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= ptr_nxt;
        end
    end
`endif

    // Empty arbitration round with a free slot drains the output.
    always_ff @(posedge clock) begin
        if (reset) begin
            wbck_o_valid  <= 1'b0;
            wbck_o_op     <= '0;
            wbck_o_pc     <= '0;
            wbck_o_rd     <= '0;
            wbck_o_data   <= '0;
            wbck_o_lsu    <= 1'b0;
            wbck_o_mmio   <= 1'b0;
            wbck_o_ebreak <= 1'b0;
            wen_q         <= 1'b0;
        end else if (adv) begin
            wbck_o_valid <= hs;
            if (hs) begin
                wbck_o_op     <= gnt;
                wbck_o_pc     <= sel_pc;
                wbck_o_rd     <= sel_rd;
                wbck_o_data   <= sel_data;
                wbck_o_lsu    <= gnt[LSU_CH];
                wbck_o_mmio   <= sel_mmio;
                wbck_o_ebreak <= sel_ebreak;
                wen_q         <= sel_wen;
            end
        end
    end

endmodule

// File: tb/tb_lieat_exu_wbarb.sv
// tb_lieat_exu_wbarb: directed and random checks of the writeback arbiter
// against a behavioural channel-picking model.
module tb_lieat_exu_wbarb;

    localparam int N  = 3;
    localparam int XL = 64;
    localparam int RI = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  ch_valid;
    logic [N-1:0]  ch_ready;
    logic [N*XL-1:0] ch_pc;
    logic [N-1:0]  ch_wen;
    logic [N*RI-1:0] ch_rd;
    logic [N*XL-1:0] ch_data;
    logic [N-1:0]  ch_ebreak;
    logic [N-1:0]  ch_mmio;
    logic [N-1:0]  waw_dep;
    logic          wbck_o_valid;
    logic          wbck_o_ready;
    logic [N-1:0]  wbck_o_op;
    logic [XL-1:0] wbck_o_pc;
    logic          wbck_o_en;
    logic [RI-1:0] wbck_o_rd;
    logic [XL-1:0] wbck_o_data;
    logic          wbck_o_lsu;
    logic          wbck_o_mmio;
    logic          wbck_o_ebreak;

    always #5 clock = ~clock;

    lieat_exu_wbarb #(
        .NUM_CH  (N),
        .XLEN    (XL),
        .REG_IDX (RI),
        .LSU_CH  (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ch_valid      (ch_valid),
        .ch_ready      (ch_ready),
        .ch_pc         (ch_pc),
        .ch_wen        (ch_wen),
        .ch_rd         (ch_rd),
        .ch_data       (ch_data),
        .ch_ebreak     (ch_ebreak),
        .ch_mmio       (ch_mmio),
        .waw_dep       (waw_dep),
        .wbck_o_valid  (wbck_o_valid),
        .wbck_o_ready  (wbck_o_ready),
        .wbck_o_op     (wbck_o_op),
        .wbck_o_pc     (wbck_o_pc),
        .wbck_o_en     (wbck_o_en),
        .wbck_o_rd     (wbck_o_rd),
        .wbck_o_data   (wbck_o_data),
        .wbck_o_lsu    (wbck_o_lsu),
        .wbck_o_mmio   (wbck_o_mmio),
        .wbck_o_ebreak (wbck_o_ebreak)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: next-search start and the item held at the output.
    int            m_ptr = 0;
    bit            m_vld = 0;
    int            m_src = 0;
    logic [XL-1:0] m_pc = '0;
    logic [XL-1:0] m_data = '0;
    logic [RI-1:0] m_rd = '0;
    bit            m_wen = 0;
    bit            m_eb = 0;
    bit            m_mmio = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int start;
        if (reset) return -1;
        if (m_vld && !wbck_o_ready) return -1;
`ifdef LIEAT_WBARB_FIXPRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (ch_valid[j] && !waw_dep[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_ch(input int i, input bit v, input logic [63:0] data,
                          input logic [4:0] rd, input bit wen, input bit eb);
        ch_valid[i]          = v;
        ch_data[i*XL +: XL]  = data;
        ch_rd[i*RI +: RI]    = rd;
        ch_wen[i]            = wen;
        ch_ebreak[i]         = eb;
        ch_pc[i*XL +: XL]    = 64'h1000 + 64'(i * 4);
        ch_mmio[i]           = (i == 1);
    endtask

    task automatic cycle(input string tag);
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = pick();
        exp_rdy = (g < 0) ? '0 : N'(1 << g);
        check({tag, ".ready"}, 64'(ch_ready), 64'(exp_rdy));
        @(posedge clock);
        if (reset) begin
            m_vld = 0; m_ptr = 0; m_src = 0;
        end else if (!m_vld || wbck_o_ready) begin
            if (g >= 0) begin
                m_vld  = 1;
                m_src  = g;
                m_pc   = ch_pc[g*XL +: XL];
                m_data = ch_data[g*XL +: XL];
                m_rd   = ch_rd[g*RI +: RI];
                m_wen  = ch_wen[g];
                m_eb   = ch_ebreak[g];
                m_mmio = ch_mmio[g];
                m_ptr  = (g + 1) % N;
            end else begin
                m_vld = 0;
            end
        end
        #1;
        check({tag, ".valid"}, 64'(wbck_o_valid), 64'(m_vld));
        check({tag, ".en"}, 64'(wbck_o_en), 64'(m_vld && m_wen));
        if (m_vld) begin
            check({tag, ".op"}, 64'(wbck_o_op), 64'(1 << m_src));
            check({tag, ".pc"}, wbck_o_pc, m_pc);
            check({tag, ".data"}, wbck_o_data, m_data);
            check({tag, ".rd"}, 64'(wbck_o_rd), 64'(m_rd));
            check({tag, ".lsu"}, 64'(wbck_o_lsu), 64'(m_src == 1));
            check({tag, ".mmio"}, 64'(wbck_o_mmio), 64'(m_mmio));
            check({tag, ".ebreak"}, 64'(wbck_o_ebreak), 64'(m_eb));
        end
    endtask

    initial begin
        reset = 1; wbck_o_ready = 1; waw_dep = '0;
        ch_valid = '0; ch_pc = '0; ch_wen = '0; ch_rd = '0;
        ch_data = '0; ch_ebreak = '0; ch_mmio = '0;
        set_ch(0, 1, 64'h1111, 5'd1, 1, 0);
        set_ch(1, 1, 64'h2222, 5'd2, 1, 0);
        set_ch(2, 1, 64'h3333, 5'd3, 1, 0);
        @(posedge clock); #1;

        // Reset with every channel requesting.
        cycle("rst0");
        cycle("rst1");
        check("rst.ch_ready", 64'(ch_ready), 64'h0);
        check("rst.valid", 64'(wbck_o_valid), 64'h0);
        check("rst.op", 64'(wbck_o_op), 64'h0);
        check("rst.en", 64'(wbck_o_en), 64'h0);
        check("rst.lsu", 64'(wbck_o_lsu), 64'h0);
        check("rst.mmio", 64'(wbck_o_mmio), 64'h0);
        check("rst.ebreak", 64'(wbck_o_ebreak), 64'h0);
        check("rst.pc", wbck_o_pc, 64'h0);
        check("rst.rd", 64'(wbck_o_rd), 64'h0);
        check("rst.data", wbck_o_data, 64'h0);

        reset = 0;
        #1;
        check("first.gnt", 64'(ch_ready), 64'b001);
        cycle("first");
        check("first.op", 64'(wbck_o_op), 64'b001);
        check("first.data", wbck_o_data, 64'h1111);

`ifndef LIEAT_WBARB_FIXPRIO_EN
        cycle("rot1");
        check("rot1.op", 64'(wbck_o_op), 64'b010);
        check("rot1.valid", 64'(wbck_o_valid), 64'h1);
        cycle("rot2");
        check("rot2.op", 64'(wbck_o_op), 64'b100);
        check("rot2.valid", 64'(wbck_o_valid), 64'h1);
        cycle("rot3");
        check("rot3.op", 64'(wbck_o_op), 64'b001);
        check("rot3.valid", 64'(wbck_o_valid), 64'h1);
`else
        for (int k = 0; k < 3; k++) begin
            cycle("fix");
            check("fix.op", 64'(wbck_o_op), 64'b001);
        end
`endif

        // LSU result held through a downstream stall.
        set_ch(0, 0, 64'h1111, 5'd1, 1, 0);
        set_ch(2, 0, 64'h3333, 5'd3, 1, 0);
        set_ch(1, 1, 64'hDEAD, 5'd5, 1, 0);
        cycle("lsu");
        check("lsu.data", wbck_o_data, 64'hDEAD);
        check("lsu.lsu", 64'(wbck_o_lsu), 64'h1);
        wbck_o_ready = 0;
        set_ch(1, 1, 64'hBEEF, 5'd6, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall.ch_ready", 64'(ch_ready), 64'h0);
            cycle("stall");
            check("stall.data", wbck_o_data, 64'hDEAD);
            check("stall.rd", 64'(wbck_o_rd), 64'd5);
            check("stall.lsu", 64'(wbck_o_lsu), 64'h1);
        end
        wbck_o_ready = 1;
        #1;
        check("resume.ch_ready", 64'(ch_ready), 64'b010);
        cycle("resume");
        check("resume.data", wbck_o_data, 64'hBEEF);

        // Non-writing entry still takes a beat.
        set_ch(1, 0, 64'h2222, 5'd2, 1, 0);
        set_ch(2, 1, 64'h4444, 5'd7, 0, 1);
        cycle("nowen");
        check("nowen.valid", 64'(wbck_o_valid), 64'h1);
        check("nowen.en", 64'(wbck_o_en), 64'h0);
        check("nowen.ebreak", 64'(wbck_o_ebreak), 64'h1);

        // WAW hazard on ch0 lets ch2 through first.
        set_ch(2, 1, 64'h3333, 5'd3, 1, 0);
        set_ch(0, 1, 64'h1111, 5'd1, 1, 0);
        waw_dep = 3'b001;
        #1;
        check("waw.gnt", 64'(ch_ready), 64'b100);
        cycle("waw");
        check("waw.op", 64'(wbck_o_op), 64'b100);
        waw_dep = 3'b000;
        #1;
        check("wawclr.gnt", 64'(ch_ready), 64'b001);
        cycle("wawclr");
        check("wawclr.op", 64'(wbck_o_op), 64'b001);
        check("wawclr.data", wbck_o_data, 64'h1111);

        // Every requester blocked: no grant, output drains.
        waw_dep = 3'b101;
        #1;
        check("blk.ch_ready", 64'(ch_ready), 64'h0);
        cycle("blk0");
        check("blk0.valid", 64'(wbck_o_valid), 64'h0);
        cycle("blk1");
        waw_dep = 3'b000;
        cycle("unblk");
        check("unblk.valid", 64'(wbck_o_valid), 64'h1);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                set_ch(i, $urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                       5'($urandom()), 1'($urandom()), 1'($urandom_range(0, 7) == 0));
                ch_mmio[i] = 1'($urandom());
            end
            waw_dep      = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '0;
            wbck_o_ready = $urandom_range(0, 3) != 0;
            cycle("rnd");
        end

        // Reset while an output is pending drops it.
        waw_dep = '0;
        for (int i = 0; i < N; i++) set_ch(i, 1, 64'h5000 + 64'(i), 5'(i), 1, 0);
        wbck_o_ready = 0;
        cycle("pend0");
        cycle("pend1");
        check("pend.valid", 64'(wbck_o_valid), 64'h1);
        reset = 1;
        cycle("midrst");
        check("midrst.valid", 64'(wbck_o_valid), 64'h0);
        check("midrst.en", 64'(wbck_o_en), 64'h0);
        reset = 0;
        wbck_o_ready = 1;
        cycle("after");
        check("after.op", 64'(wbck_o_op), 64'b001);
        check("after.data", wbck_o_data, 64'h5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
